// File: rtl/gate_direction_sequencer_pkg.sv
// Shared types for the gate direction sequencer: FSM state encoding and
// the counter-width helper used by the sensor debouncers.
package gate_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        IN_A     = 3'd1,
        IN_AB    = 3'd2,
        IN_B     = 3'd3,
        OUT_B    = 3'd4,
        OUT_BA   = 3'd5,
        OUT_A    = 3'd6,
        WAIT_CLR = 3'd7
    } state_t;

    localparam int DWELL_W = 16;

    // A single-cycle debounce still needs a 1-bit counter to keep widths legal.
    function automatic int deb_cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gate_direction_sequencer_if.sv
// Sensor/status inputs and request pulses between the gate sequencer and
// the occupancy block.
interface gate_direction_sequencer_if;
    import gate_pkg::*;

    logic   sens_a;
    logic   sens_b;
    logic   full;
    logic   empty;
    logic   alarm;
    logic   entry_pulse;
    logic   exit_pulse;
    logic   deny_pulse;
    logic   fault_pulse;
    logic   busy;
    state_t state;

    modport master (
        output sens_a, sens_b, full, empty, alarm,
        input  entry_pulse, exit_pulse, deny_pulse, fault_pulse, busy, state
    );

    modport slave (
        input  sens_a, sens_b, full, empty, alarm,
        output entry_pulse, exit_pulse, deny_pulse, fault_pulse, busy, state
    );

endinterface

// File: rtl/gate_direction_sequencer_sensor_debounce.sv
// One beam sensor: 2-flop synchronizer followed by a stability counter that
// only lets the debounced level follow after DEBOUNCE_CYCLES matching samples.
module sensor_debounce
    import gate_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic clear,
    input  logic raw,
    output logic deb
);
    localparam int CW = deb_cnt_w(DEBOUNCE_CYCLES);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (clear) begin
            sync <= '0;
            cnt  <= '0;
            deb  <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            // Any sample agreeing with the current level restarts the count.
            if (sync[1] == deb) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                deb <= sync[1];
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gate_direction_sequencer.sv
// Gate direction sequencer: debounces the outer (A) and inner (B) beams and
// turns complete crossings into single-cycle entry/exit/deny/fault pulses.
module gate_direction_sequencer
    import gate_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input logic                        clk,
    input logic                        clear,
    gate_direction_sequencer_if.slave  bus
);
    logic [1:0] raw;
    logic [1:0] deb;
    logic       a;
    logic       b;

    assign raw = {bus.sens_b, bus.sens_a};

    generate
        for (genvar i = 0; i < 2; i++) begin : g_deb
            sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
                .clk   (clk),
                .clear (clear),
                .raw   (raw[i]),
                .deb   (deb[i])
            );
        end
    endgenerate

    assign a = deb[0];
    assign b = deb[1];

    state_t             state;
    state_t             state_nxt;
    logic [DWELL_W-1:0] dwell;
    logic               timeout;
    logic               done_in;
    logic               done_out;
    logic               entry_d;
    logic               exit_d;
    logic               deny_d;
    logic               fault_d;
    logic               entry_q;
    logic               exit_q;
    logic               deny_q;
    logic               fault_q;

    assign timeout = (state inside {IN_A, IN_AB, IN_B, OUT_B, OUT_BA, OUT_A}) &&
                     (dwell == DWELL_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_nxt = state;
        done_in   = 1'b0;
        done_out  = 1'b0;
        fault_d   = 1'b0;
        entry_d   = 1'b0;
        exit_d    = 1'b0;
        deny_d    = 1'b0;
        case (state)
            IDLE: case ({a, b})
                2'b10:   state_nxt = IN_A;
                2'b01:   state_nxt = OUT_B;
                2'b11:   begin state_nxt = WAIT_CLR; fault_d = 1'b1; end
                default: ;
            endcase
            IN_A: case ({a, b})
                2'b11:   state_nxt = IN_AB;
                2'b00:   state_nxt = IDLE;
                2'b01:   begin state_nxt = WAIT_CLR; fault_d = 1'b1; end
                default: ;
            endcase
            IN_AB: case ({a, b})
                2'b01:   state_nxt = IN_B;
                2'b10:   state_nxt = IN_A;
                2'b00:   begin state_nxt = IDLE; fault_d = 1'b1; end
                default: ;
            endcase
            IN_B: case ({a, b})
                2'b00:   begin state_nxt = IDLE; done_in = 1'b1; end
                2'b11:   state_nxt = IN_AB;
                2'b10:   begin state_nxt = WAIT_CLR; fault_d = 1'b1; end
                default: ;
            endcase
            OUT_B: case ({a, b})
                2'b11:   state_nxt = OUT_BA;
                2'b00:   state_nxt = IDLE;
                2'b10:   begin state_nxt = WAIT_CLR; fault_d = 1'b1; end
                default: ;
            endcase
            OUT_BA: case ({a, b})
                2'b10:   state_nxt = OUT_A;
                2'b01:   state_nxt = OUT_B;
                2'b00:   begin state_nxt = IDLE; fault_d = 1'b1; end
                default: ;
            endcase
            OUT_A: case ({a, b})
                2'b00:   begin state_nxt = IDLE; done_out = 1'b1; end
                2'b11:   state_nxt = OUT_BA;
                2'b01:   begin state_nxt = WAIT_CLR; fault_d = 1'b1; end
                default: ;
            endcase
            WAIT_CLR: if (!a && !b) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase

        // A real transition wins over a timeout landing on the same cycle.
        if (timeout && state_nxt == state) begin
            state_nxt = WAIT_CLR;
            fault_d   = 1'b1;
        end

        if (done_in) begin
            if (bus.full || bus.alarm) deny_d  = 1'b1;
            else                       entry_d = 1'b1;
        end
        if (done_out) begin
            if (bus.empty) deny_d = 1'b1;
            else           exit_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state   <= IDLE;
            dwell   <= '0;
            entry_q <= 1'b0;
            exit_q  <= 1'b0;
            deny_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            entry_q <= entry_d;
            exit_q  <= exit_d;
            deny_q  <= deny_d;
            fault_q <= fault_d;
            if (state_nxt != state)  dwell <= '0;
            else if (dwell != '1)    dwell <= dwell + 1'b1;
        end
    end

    assign bus.entry_pulse = entry_q;
    assign bus.exit_pulse  = exit_q;
    assign bus.deny_pulse  = deny_q;
    assign bus.fault_pulse = fault_q;
    assign bus.busy        = (state != IDLE);
    assign bus.state       = state;

endmodule

// File: tb/tb_gate_direction_sequencer.sv
// Scenario bench for gate_direction_sequencer with a pulse scoreboard.
module tb_gate_direction_sequencer;
    import gate_pkg::*;

    localparam int DEB = 4;
    localparam int TMO = 16;

    localparam int C_ENTRY = 1;
    localparam int C_EXIT  = 2;
    localparam int C_DENY  = 3;
    localparam int C_FAULT = 4;
    localparam int C_MULTI = 9;

    logic clk   = 1'b0;
    logic clear = 1'b1;

    gate_direction_sequencer_if gif();

    gate_direction_sequencer #(
        .DEBOUNCE_CYCLES (DEB),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (gif.slave)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_q[$];

    // Advance n cycles, sampling on the falling edge; every observed pulse is
    // popped against the expected queue.
    task automatic step(input int n);
        int code;
        int e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            code = 0;
            if (gif.entry_pulse) code = C_ENTRY;
            if (gif.exit_pulse)  code = (code != 0) ? C_MULTI : C_EXIT;
            if (gif.deny_pulse)  code = (code != 0) ? C_MULTI : C_DENY;
            if (gif.fault_pulse) code = (code != 0) ? C_MULTI : C_FAULT;
            if (code != 0) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL pulse_sb: unexpected pulse code %0d, expected none", code);
                end else begin
                    e = exp_q.pop_front();
                    if (code !== e) begin
                        tests_failed++;
                        $display("FAIL pulse_sb: pulse code %0d, expected %0d", code, e);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        clear = 1'b1;
        step(3);
        tests_run++;
        if (gif.state !== IDLE || gif.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: state=%0d busy=%0b, expected 0/0", gif.state, gif.busy);
        end
        tests_run++;
        if ({gif.entry_pulse, gif.exit_pulse, gif.deny_pulse, gif.fault_pulse} !== 4'b0) begin
            tests_failed++;
            $display("FAIL reset_pulses: %b, expected 0000",
                     {gif.entry_pulse, gif.exit_pulse, gif.deny_pulse, gif.fault_pulse});
        end
        clear = 1'b0;
        step(1);
    endtask

    task automatic test_entry(input logic full, input logic alarm, input int exp, input string name);
        gif.full = full; gif.alarm = alarm;
        gif.sens_a = 1'b1; step(10);
        gif.sens_b = 1'b1; step(10);
        gif.sens_a = 1'b0; step(10);
        tests_run++;
        if (gif.state !== IN_B) begin
            tests_failed++;
            $display("FAIL %s_in_b: state=%0d, expected %0d", name, gif.state, IN_B);
        end
        exp_q.push_back(exp);
        gif.sens_b = 1'b0; step(12);
        tests_run++;
        if (gif.state !== IDLE || gif.busy !== 1'b0 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_done: state=%0d busy=%0b pending=%0d, expected 0/0/0",
                     name, gif.state, gif.busy, exp_q.size());
            exp_q.delete();
        end
        gif.full = 1'b0; gif.alarm = 1'b0;
    endtask

    task automatic test_exit(input logic empty, input logic alarm, input int exp, input string name);
        gif.empty = empty; gif.alarm = alarm;
        gif.sens_b = 1'b1; step(10);
        gif.sens_a = 1'b1; step(10);
        gif.sens_b = 1'b0; step(10);
        tests_run++;
        if (gif.state !== OUT_A) begin
            tests_failed++;
            $display("FAIL %s_out_a: state=%0d, expected %0d", name, gif.state, OUT_A);
        end
        exp_q.push_back(exp);
        gif.sens_a = 1'b0; step(12);
        tests_run++;
        if (gif.state !== IDLE || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_done: state=%0d pending=%0d, expected 0/0", name, gif.state, exp_q.size());
            exp_q.delete();
        end
        gif.empty = 1'b0; gif.alarm = 1'b0;
    endtask

    task automatic test_glitch();
        logic seen_busy;
        seen_busy = 1'b0;
        gif.sens_a = 1'b1; step(3);
        gif.sens_a = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step(1);
            if (gif.busy) seen_busy = 1'b1;
        end
        tests_run++;
        if (seen_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch: busy seen=%0b, expected 0", seen_busy);
        end
    endtask

    task automatic test_backout();
        gif.sens_a = 1'b1; step(12);
        tests_run++;
        if (gif.state !== IN_A) begin
            tests_failed++;
            $display("FAIL backout_in_a: state=%0d, expected %0d", gif.state, IN_A);
        end
        gif.sens_a = 1'b0; step(12);
        tests_run++;
        if (gif.state !== IDLE) begin
            tests_failed++;
            $display("FAIL backout_idle: state=%0d, expected 0", gif.state);
        end
    endtask

    task automatic test_timeout();
        int n;
        exp_q.push_back(C_FAULT);
        gif.sens_a = 1'b1;
        n = 0;
        while (gif.state !== IN_A && n < 20) begin step(1); n++; end
        tests_run++;
        if (gif.state !== IN_A) begin
            tests_failed++;
            $display("FAIL timeout_enter: state=%0d after %0d cycles, expected %0d", gif.state, n, IN_A);
        end
        n = 0;
        while (gif.fault_pulse !== 1'b1 && n < 40) begin step(1); n++; end
        tests_run++;
        if (n != TMO) begin
            tests_failed++;
            $display("FAIL timeout_cycles: fault after %0d cycles, expected %0d", n, TMO);
        end
        tests_run++;
        if (gif.state !== WAIT_CLR) begin
            tests_failed++;
            $display("FAIL timeout_state: state=%0d, expected %0d", gif.state, WAIT_CLR);
        end
        gif.sens_a = 1'b0; step(12);
        tests_run++;
        if (gif.state !== IDLE || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL timeout_clear: state=%0d pending=%0d, expected 0/0", gif.state, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_illegal();
        exp_q.push_back(C_FAULT);
        gif.sens_a = 1'b1; gif.sens_b = 1'b1; step(10);
        tests_run++;
        if (gif.state !== WAIT_CLR) begin
            tests_failed++;
            $display("FAIL illegal_state: state=%0d, expected %0d", gif.state, WAIT_CLR);
        end
        gif.sens_a = 1'b0; gif.sens_b = 1'b0; step(10);
        tests_run++;
        if (gif.state !== IDLE || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL illegal_clear: state=%0d pending=%0d, expected 0/0", gif.state, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        exp_q.push_back(C_ENTRY);
        exp_q.push_back(C_EXIT);
        gif.sens_a = 1'b1; step(8);
        gif.sens_b = 1'b1; step(8);
        gif.sens_a = 1'b0; step(8);
        gif.sens_b = 1'b0; step(8);
        gif.sens_b = 1'b1; step(8);
        gif.sens_a = 1'b1; step(8);
        gif.sens_b = 1'b0; step(8);
        gif.sens_a = 1'b0; step(12);
        tests_run++;
        if (gif.state !== IDLE || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL back_to_back: state=%0d pending=%0d, expected 0/0", gif.state, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        gif.sens_a = 1'b1; step(10);
        gif.sens_b = 1'b1; step(10);
        tests_run++;
        if (gif.state !== IN_AB) begin
            tests_failed++;
            $display("FAIL midreset_in_ab: state=%0d, expected %0d", gif.state, IN_AB);
        end
        clear = 1'b1; gif.sens_a = 1'b0; gif.sens_b = 1'b0;
        step(1);
        tests_run++;
        if (gif.state !== IDLE || gif.busy !== 1'b0 ||
            {gif.entry_pulse, gif.exit_pulse, gif.deny_pulse, gif.fault_pulse} !== 4'b0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: state=%0d busy=%0b pulses=%b, expected 0/0/0000",
                     gif.state, gif.busy,
                     {gif.entry_pulse, gif.exit_pulse, gif.deny_pulse, gif.fault_pulse});
        end
        clear = 1'b0; step(15);
        tests_run++;
        if (gif.state !== IDLE) begin
            tests_failed++;
            $display("FAIL midreset_after: state=%0d, expected 0", gif.state);
        end
    endtask

    initial begin
        gif.sens_a = 1'b0; gif.sens_b = 1'b0;
        gif.full = 1'b0; gif.empty = 1'b0; gif.alarm = 1'b0;
        test_reset();
        test_entry(1'b0, 1'b0, C_ENTRY, "entry");
        test_exit(1'b0, 1'b0, C_EXIT, "exit");
        test_exit(1'b1, 1'b0, C_DENY, "exit_empty");
        test_entry(1'b1, 1'b0, C_DENY, "entry_full");
        test_entry(1'b0, 1'b1, C_DENY, "entry_alarm");
        test_exit(1'b0, 1'b1, C_EXIT, "exit_alarm");
        test_glitch();
        test_backout();
        test_timeout();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
